// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C byte-level initiator: command codes,
// controller states and the quarter-phase indices of one SCL period.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT_W = 3'd2,
    ST_BIT_R = 3'd3,
    ST_ACK_W = 3'd4,
    ST_ACK_R = 3'd5,
    ST_STOP  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [1:0] PH_Q0 = 2'd0;
  localparam logic [1:0] PH_Q1 = 2'd1;
  localparam logic [1:0] PH_Q2 = 2'd2;
  localparam logic [1:0] PH_Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-period timer for SCL generation. Counts QTR clocks per quarter and
// steps the quarter index Q0..Q3. Freezes while we release SCL but the pad
// still reads low, so a stretching slave slows the whole bit down.
module i2c_qtr_timer #(
  parameter int QTR = 25
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       run,
  input  logic       scl_drv,
  input  logic       scl_pad,
  output logic       qtr_tick,
  output logic [1:0] q,
  output logic       qtr_first
);

  localparam int QTR_W = $clog2(QTR);
  localparam logic [QTR_W-1:0] CNT_MAX = QTR_W'(QTR - 1);

  logic [QTR_W-1:0] cnt;
  logic             en;

  // counting is enabled only for bus commands and while SCL is not being stretched
  assign en        = run && !(scl_drv && !scl_pad);
  assign qtr_tick  = en && (cnt == CNT_MAX);
  assign qtr_first = en && (cnt == '0);

  // quarter cycle counter and quarter index
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 2'd0;
    end else if (clr) begin
      cnt <= '0;
      q   <= 2'd0;
    end else if (en) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        q   <= q + 2'd1;
      end else begin
        cnt <= cnt + QTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C initiator. Accepts START / WRITE / READ / STOP commands over
// a valid/ready handshake and sequences the open-drain SCL/SDA pads quarter by
// quarter. Pad enables come directly from flops; a pad change lands on the
// first cycle of each quarter, so every quarter keeps its full length.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int QTR = 25
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       rack_i,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_e     state;
  state_e     state_nx;
  logic       accept;
  logic       run;
  logic       qtr_tick;
  logic       qtr_first;
  logic [1:0] q;
  logic       last_q;
  logic       q3_first;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rack_r;
  logic       scl_nx;
  logic       sda_nx;

  assign accept   = cmd_valid_i && cmd_ready_o;
  assign run      = (state inside {ST_START, ST_BIT_W, ST_BIT_R, ST_ACK_W, ST_ACK_R, ST_STOP});
  assign last_q   = qtr_tick && (q == PH_Q3);
  assign q3_first = qtr_first && (q == PH_Q3);

  i2c_qtr_timer #(
    .QTR(QTR)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .clr       (accept),
    .run       (run),
    .scl_drv   (scl_o),
    .scl_pad   (scl_i),
    .qtr_tick  (qtr_tick),
    .q         (q),
    .qtr_first (qtr_first)
  );

  // controller state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state: bus commands run four quarters per bit, idle-bus data commands finish at once
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_i)
            CMD_START: state_nx = ST_START;
            CMD_WRITE: state_nx = busy_o ? ST_BIT_W : ST_DONE;
            CMD_READ:  state_nx = busy_o ? ST_BIT_R : ST_DONE;
            CMD_STOP:  state_nx = busy_o ? ST_STOP : ST_DONE;
            default:   state_nx = ST_DONE;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BIT_W: begin
        if (last_q) begin
          state_nx = (bit_cnt == 3'd7) ? ST_ACK_R : ST_BIT_W;
        end else begin
          state_nx = ST_BIT_W;
        end
      end
      ST_BIT_R: begin
        if (last_q) begin
          state_nx = (bit_cnt == 3'd7) ? ST_ACK_W : ST_BIT_R;
        end else begin
          state_nx = ST_BIT_R;
        end
      end
      ST_START, ST_ACK_W, ST_ACK_R, ST_STOP: begin
        if (last_q) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = state;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // next pad levels: set on the first cycle of each quarter, SCL parked low after a START or byte
  always_comb begin
    scl_nx = scl_o;
    sda_nx = sda_o;
    if (qtr_first) begin
      case (state)
        ST_START: begin
          case (q)
            PH_Q0:   sda_nx = 1'b1;
            PH_Q1:   scl_nx = 1'b1;
            default: sda_nx = 1'b0;
          endcase
        end
        ST_BIT_W, ST_BIT_R, ST_ACK_W, ST_ACK_R: begin
          if (!q[1]) begin
            scl_nx = 1'b0;
            case (state)
              ST_BIT_W: sda_nx = shreg[7];
              ST_ACK_W: sda_nx = rack_r;
              default:  sda_nx = 1'b1;
            endcase
          end else begin
            scl_nx = 1'b1;
          end
        end
        ST_STOP: begin
          case (q)
            PH_Q0: begin
              scl_nx = 1'b0;
              sda_nx = 1'b0;
            end
            PH_Q1: begin
              scl_nx = 1'b1;
              sda_nx = 1'b0;
            end
            default: sda_nx = 1'b1;
          endcase
        end
        default: begin
          scl_nx = scl_o;
          sda_nx = sda_o;
        end
      endcase
    end else if ((state == ST_DONE) && busy_o) begin
      scl_nx = 1'b0;
    end else begin
      scl_nx = scl_o;
    end
  end

  // pad enable flops, released on reset
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_o <= 1'b1;
      sda_o <= 1'b1;
    end else begin
      scl_o <= scl_nx;
      sda_o <= sda_nx;
    end
  end

  // handshake, bus ownership, shift data, ACK capture and received byte
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      ack_o       <= 1'b1;
      rdata_o     <= 8'h00;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rack_r      <= 1'b0;
    end else begin
      done_o <= (state == ST_DONE);
      if (accept) begin
        cmd_ready_o <= 1'b0;
      end else if (done_o) begin
        cmd_ready_o <= 1'b1;
      end
      if (accept) begin
        shreg   <= wdata_i;
        rack_r  <= rack_i;
        bit_cnt <= 3'd0;
        if (cmd_i == CMD_START) begin
          busy_o <= 1'b1;
        end else if (!busy_o) begin
          ack_o <= 1'b1;
        end
      end else begin
        case (state)
          ST_BIT_W: begin
            if (last_q) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_BIT_R: begin
            if (q3_first) begin
              rdata_o <= {rdata_o[6:0], sda_i};
            end
            if (last_q) begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_ACK_R: begin
            if (q3_first) begin
              ack_o <= sda_i;
            end
          end
          ST_STOP: begin
            if (last_q) begin
              busy_o <= 1'b0;
            end
          end
          default: begin
            bit_cnt <= bit_cnt;
          end
        endcase
      end
    end
  end

endmodule
